// File: rtl/wb_io_wr_bridge.sv
// Wishbone slave to timed memory/IO bus cycle: CS decode, setup/strobe/hold sequencing, read capture.
// Optional IORDY_WAIT_EN adds an IORDY input that stretches the strobe on IO-space cycles.
module wb_io_wr_bridge #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_tga_i,
   input  logic [15:0] wb_adr_i,
   input  logic [1:0]  wb_sel_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic [15:0] rd_dat_i,
   output logic [15:0] ADDR,
   output logic [15:0] IODATO,
   output logic        RDN,
   output logic        WRN,
   output logic        BHEN_N,
   output logic        BLEN_N,
   output logic        MEMCS_N,
   output logic        IOCS0_N,
   output logic        IOCS1_N,
   output logic        IOCS2_N
`ifdef IORDY_WAIT_EN
   ,
   input  logic        IORDY
`endif
);

   localparam logic [3:0] SETUP_N  = (SETUP_CYC  == 0) ? 4'd1 : SETUP_CYC[3:0];
   localparam logic [3:0] STROBE_N = (STROBE_CYC == 0) ? 4'd1 : STROBE_CYC[3:0];
   localparam logic [3:0] HOLD_N   = (HOLD_CYC   == 0) ? 4'd1 : HOLD_CYC[3:0];

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        lat_we_q, lat_we_d;
   logic        lat_tga_q, lat_tga_d;
   logic [15:0] lat_adr_q, lat_adr_d;
   logic [15:0] lat_dat_q, lat_dat_d;
   logic [1:0]  lat_sel_q, lat_sel_d;

   logic [15:0] wb_dat_q, wb_dat_d;
   logic        wb_ack_q, wb_ack_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] iodato_q, iodato_d;
   logic        rdn_q, rdn_d;
   logic        wrn_q, wrn_d;
   logic        bhen_n_q, bhen_n_d;
   logic        blen_n_q, blen_n_d;
   logic        memcs_n_q, memcs_n_d;
   logic        iocs0_n_q, iocs0_n_d;
   logic        iocs1_n_q, iocs1_n_d;
   logic        iocs2_n_q, iocs2_n_d;

   logic        req;
   logic        wait_io;
   logic        capture;
   logic        active;

   assign req = wb_cyc_i & wb_stb_i;

`ifdef IORDY_WAIT_EN
   assign wait_io = lat_tga_q & ~IORDY;
`else
   assign wait_io = 1'b0;
`endif

   // Read data is sampled on the edge that ends the final strobe cycle, unless the cycle aborts.
   assign capture = (state_q == S_STROBE) & wb_cyc_i & (cnt_q == 4'd0) & ~wait_io & ~lat_we_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_N - 4'd1;
            end
         end
         S_SETUP: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_N - 4'd1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               if (!wait_io) begin
                  state_d = S_HOLD;
                  cnt_d   = HOLD_N - 4'd1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (!wb_cyc_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state so the registered pins line up with the state they belong to.
   always_comb begin
      lat_we_d  = lat_we_q;
      lat_tga_d = lat_tga_q;
      lat_adr_d = lat_adr_q;
      lat_dat_d = lat_dat_q;
      lat_sel_d = lat_sel_q;
      if ((state_q == S_IDLE) && req) begin
         lat_we_d  = wb_we_i;
         lat_tga_d = wb_tga_i;
         lat_adr_d = wb_adr_i;
         lat_dat_d = wb_dat_i;
         lat_sel_d = wb_sel_i;
      end

      active    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      addr_d    = active ? lat_adr_d : 16'h0000;
      iodato_d  = (active && lat_we_d) ? lat_dat_d : 16'h0000;
      bhen_n_d  = ~(active & lat_sel_d[1]);
      blen_n_d  = ~(active & lat_sel_d[0]);
      memcs_n_d = ~(active & ~lat_tga_d);
      iocs0_n_d = ~(active & lat_tga_d & (lat_adr_d[15:4] == 12'h000));
      iocs1_n_d = ~(active & lat_tga_d & (lat_adr_d[15:4] == 12'h001));
      iocs2_n_d = ~(active & lat_tga_d & (lat_adr_d[15:4] == 12'h002));
      rdn_d     = ~((state_d == S_STROBE) & ~lat_we_d);
      wrn_d     = ~((state_d == S_STROBE) &  lat_we_d);
      wb_ack_d  = (state_d == S_ACK);
      wb_dat_d  = capture ? rd_dat_i : wb_dat_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_we_q  <= 1'b0;
         lat_tga_q <= 1'b0;
         lat_adr_q <= 16'h0000;
         lat_dat_q <= 16'h0000;
         lat_sel_q <= 2'b00;
         wb_dat_q  <= 16'h0000;
         wb_ack_q  <= 1'b0;
         addr_q    <= 16'h0000;
         iodato_q  <= 16'h0000;
         rdn_q     <= 1'b1;
         wrn_q     <= 1'b1;
         bhen_n_q  <= 1'b1;
         blen_n_q  <= 1'b1;
         memcs_n_q <= 1'b1;
         iocs0_n_q <= 1'b1;
         iocs1_n_q <= 1'b1;
         iocs2_n_q <= 1'b1;
      end else begin
         lat_we_q  <= lat_we_d;
         lat_tga_q <= lat_tga_d;
         lat_adr_q <= lat_adr_d;
         lat_dat_q <= lat_dat_d;
         lat_sel_q <= lat_sel_d;
         wb_dat_q  <= wb_dat_d;
         wb_ack_q  <= wb_ack_d;
         addr_q    <= addr_d;
         iodato_q  <= iodato_d;
         rdn_q     <= rdn_d;
         wrn_q     <= wrn_d;
         bhen_n_q  <= bhen_n_d;
         blen_n_q  <= blen_n_d;
         memcs_n_q <= memcs_n_d;
         iocs0_n_q <= iocs0_n_d;
         iocs1_n_q <= iocs1_n_d;
         iocs2_n_q <= iocs2_n_d;
      end
   end

   assign wb_dat_o = wb_dat_q;
   assign wb_ack_o = wb_ack_q;
   assign ADDR     = addr_q;
   assign IODATO   = iodato_q;
   assign RDN      = rdn_q;
   assign WRN      = wrn_q;
   assign BHEN_N   = bhen_n_q;
   assign BLEN_N   = blen_n_q;
   assign MEMCS_N  = memcs_n_q;
   assign IOCS0_N  = iocs0_n_q;
   assign IOCS1_N  = iocs1_n_q;
   assign IOCS2_N  = iocs2_n_q;

endmodule
